tennis_core_param: RTL and testbench

Parametrised game core for the FPGA tennis project. It moves a one-hot ball across N_LEDS lights, adjudicates hits, early swings and misses for two players, keeps score, and ramps ball speed.
It contains its own ball-step timer, so it runs from the system clock rather than a derived slow clock. A squash mode lets one player rally against a wall. It sits between the button synchroniser/debouncer and the LED and seven-segment drivers.

---
 rtl/tennis_core_param.sv | 191 +++++++++++++++++++
 tb/tb_tennis_core_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tennis_core_param.sv
// Two-player LED tennis core with on-chip ball-step timer, scoring, speed ramp
// and a single-player squash mode.
module tennis_core_param #(
  parameter int N_LEDS      = 16,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 3,
  parameter int EARLY_LIMIT = 3,
  parameter int SPEED_W     = 26,
  parameter int SPEED_INIT  = 40000000,
  parameter int SPEED_STEP  = 2000000,
  parameter int SPEED_MIN   = 4000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         hit,
  input  logic               squash,
  input  logic               start,
  output logic [N_LEDS-1:0]  leds,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               server,
  output logic               winner,
  output logic               hit_ok,
  output logic [1:0]         early,
  output logic [1:0]         miss
);
  localparam int PW = $clog2(N_LEDS);
  localparam int EW = $clog2(EARLY_LIMIT + 1);
  localparam logic [PW-1:0]      LAST     = PW'(N_LEDS - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_STEP = SPEED_W'(SPEED_STEP);
  localparam logic [SPEED_W-1:0] SPD_MIN  = SPEED_W'(SPEED_MIN);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [EW-1:0]      ELAST    = EW'(EARLY_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, SERVE, RALLY, POINT, GAMEOVER} state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        pos, pos_nx;
  logic                 dir, dir_nx;          // 1 = moving toward player 1
  logic                 sq_mode, sq_mode_nx;
  logic [1:0][EW-1:0]   ecnt, ecnt_nx;
  logic [SPEED_W-1:0]   timer, speed_nx;
  logic [SCORE_W-1:0]   score0_nx, score1_nx;
  logic                 server_nx, winner_nx, hit_ok_nx;
  logic [1:0]           early_nx, miss_nx;
  logic [N_LEDS-1:0]    leds_nx;
  logic                 step, rcv, at_end, lose;
  logic [SPEED_W:0]     spd_dec;

  // >= rather than == so a period shortened mid-count still terminates
  assign step    = timer >= (ball_speed - SPEED_W'(1));
  assign rcv     = dir;
  assign at_end  = pos == (dir ? LAST : '0);
  assign spd_dec = {1'b0, ball_speed} - {1'b0, SPD_STEP};

  always_comb begin
    leds_nx = '0;
    case (state)
      IDLE, SERVE: leds_nx[server ? N_LEDS-1 : 0] = 1'b1;
      GAMEOVER:    leds_nx = {N_LEDS{winner}};
      default:     leds_nx[pos] = 1'b1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    pos_nx     = pos;
    dir_nx     = dir;
    sq_mode_nx = sq_mode;
    ecnt_nx    = ecnt;
    speed_nx   = ball_speed;
    score0_nx  = score0;
    score1_nx  = score1;
    server_nx  = server;
    winner_nx  = winner;
    hit_ok_nx  = 1'b0;
    early_nx   = 2'b00;
    miss_nx    = 2'b00;
    lose       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = SERVE;
        score0_nx  = '0;
        score1_nx  = '0;
        sq_mode_nx = squash;
        if (squash) server_nx = 1'b0;
      end
      SERVE: begin
        pos_nx = server ? LAST : '0;
        dir_nx = ~server;
        if (hit[server]) state_nx = RALLY;
      end
      RALLY: begin
        if (sq_mode && dir) begin
          // heading for the wall: it always returns, no speed change
          if (step) begin
            if (at_end) dir_nx = 1'b0;
            else        pos_nx = pos + PW'(1);
          end
        end else if (hit[rcv] && at_end) begin
          dir_nx    = ~dir;
          hit_ok_nx = 1'b1;
          ecnt_nx   = '0;
          speed_nx  = (spd_dec[SPEED_W] || spd_dec[SPEED_W-1:0] < SPD_MIN) ?
                      SPD_MIN : spd_dec[SPEED_W-1:0];
          if (sq_mode && !(&score0)) score0_nx = score0 + SCORE_W'(1);
        end else begin
          if (hit[rcv]) begin
            early_nx[rcv] = 1'b1;
            if (ecnt[rcv] == ELAST) lose = 1'b1;
            else                    ecnt_nx[rcv] = ecnt[rcv] + EW'(1);
          end
          if (!lose && step) begin
            if (at_end) begin
              miss_nx[rcv] = 1'b1;
              lose         = 1'b1;
            end else begin
              pos_nx = dir ? pos + PW'(1) : pos - PW'(1);
            end
          end
          if (lose) begin
            state_nx = POINT;
            if (sq_mode)  score0_nx = '0;
            else if (rcv) score0_nx = score0 + SCORE_W'(1);
            else          score1_nx = score1 + SCORE_W'(1);
          end
        end
      end
      POINT: begin
        speed_nx = SPD_INIT;
        ecnt_nx  = '0;
        state_nx = SERVE;
        if (sq_mode) begin
          server_nx = 1'b0;
        end else begin
          server_nx = ~server;
          if (score0 == WIN || score1 == WIN) begin
            state_nx  = GAMEOVER;
            winner_nx = (score1 == WIN);
          end
        end
      end
      GAMEOVER: if (start || (|hit)) begin
        state_nx   = SERVE;
        score0_nx  = '0;
        score1_nx  = '0;
        sq_mode_nx = squash;
        server_nx  = squash ? 1'b0 : ~winner;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= '0;
      dir        <= 1'b1;
      sq_mode    <= 1'b0;
      ecnt       <= '0;
      timer      <= '0;
      leds       <= N_LEDS'(1);
      score0     <= '0;
      score1     <= '0;
      ball_speed <= SPD_INIT;
      server     <= 1'b0;
      winner     <= 1'b0;
      hit_ok     <= 1'b0;
      early      <= 2'b00;
      miss       <= 2'b00;
    end else begin
      state      <= state_nx;
      pos        <= pos_nx;
      dir        <= dir_nx;
      sq_mode    <= sq_mode_nx;
      ecnt       <= ecnt_nx;
      timer      <= (state_nx != state || step) ? '0 : timer + SPEED_W'(1);
      leds       <= leds_nx;
      score0     <= score0_nx;
      score1     <= score1_nx;
      ball_speed <= speed_nx;
      server     <= server_nx;
      winner     <= winner_nx;
      hit_ok     <= hit_ok_nx;
      early      <= early_nx;
      miss       <= miss_nx;
    end
  end
endmodule

// File: tb/tb_tennis_core_param.sv
// Bench for tennis_core_param: directed game scenarios plus random play, all
// checked every cycle against a rule-level game model.
module tb_tennis_core_param;
  localparam int N     = 8;
  localparam int SW    = 3;
  localparam int WINS  = 3;
  localparam int ELIM  = 3;
  localparam int SPW   = 8;
  localparam int SINIT = 4;
  localparam int SSTEP = 1;
  localparam int SMIN  = 2;
  localparam int M_IDLE = 0, M_SERVE = 1, M_RALLY = 2, M_POINT = 3, M_OVER = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     hit = 2'b00;
  logic           squash = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   leds;
  logic [SW-1:0]  score0, score1;
  logic [SPW-1:0] ball_speed;
  logic           server, winner, hit_ok;
  logic [1:0]     early, miss;

  tennis_core_param #(
    .N_LEDS(N), .SCORE_W(SW), .WIN_SCORE(WINS), .EARLY_LIMIT(ELIM), .SPEED_W(SPW),
    .SPEED_INIT(SINIT), .SPEED_STEP(SSTEP), .SPEED_MIN(SMIN)
  ) dut (
    .clock(clock), .reset(reset), .hit(hit), .squash(squash), .start(start),
    .leds(leds), .score0(score0), .score1(score1), .ball_speed(ball_speed),
    .server(server), .winner(winner), .hit_ok(hit_ok), .early(early), .miss(miss)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;

  // game model: ball position/heading as integers, counters as plain ints
  int m_ph, m_pos, m_head, m_sq, m_s0, m_s1, m_spd, m_srv, m_win, m_tick;
  int m_e[2];
  logic [N-1:0] e_leds;
  logic         e_ok;
  logic [1:0]   e_early, e_miss;
  logic         sq_lvl = 1'b0;
  logic [1:0]   rh;
  logic         rs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_pos = 0; m_head = 1; m_sq = 0; m_s0 = 0; m_s1 = 0;
    m_spd = SINIT; m_srv = 0; m_win = 0; m_tick = 0; m_e[0] = 0; m_e[1] = 0;
    e_leds = N'(1); e_ok = 1'b0; e_early = 2'b00; e_miss = 2'b00;
  endtask

  function automatic int rcv_of();
    return (m_head > 0) ? 1 : 0;
  endfunction

  function automatic bit at_dwell();
    return m_ph == M_RALLY && !(m_sq != 0 && m_head > 0) &&
           m_pos == ((m_head > 0) ? N - 1 : 0);
  endfunction

  task automatic model_edge(input logic [1:0] h, input logic st, input logic sq);
    int ph0, rcv, rend;
    bit step, lose;
    ph0 = m_ph;
    e_leds = '0;
    if (m_ph == M_OVER)                         e_leds = m_win != 0 ? '1 : '0;
    else if (m_ph == M_IDLE || m_ph == M_SERVE) e_leds[m_srv != 0 ? N - 1 : 0] = 1'b1;
    else                                        e_leds[m_pos] = 1'b1;
    e_ok = 1'b0; e_early = 2'b00; e_miss = 2'b00;
    step = (m_tick + 1 >= m_spd);
    case (m_ph)
      M_IDLE: if (st) begin
        m_ph = M_SERVE; m_s0 = 0; m_s1 = 0; m_sq = int'(sq);
        if (sq) m_srv = 0;
      end
      M_SERVE: begin
        m_pos = (m_srv != 0) ? N - 1 : 0;
        m_head = (m_srv != 0) ? -1 : 1;
        if (h[m_srv]) m_ph = M_RALLY;
      end
      M_RALLY: begin
        rcv = rcv_of();
        rend = (rcv != 0) ? N - 1 : 0;
        lose = 0;
        if (m_sq != 0 && rcv != 0) begin
          if (step) begin
            if (m_pos == N - 1) m_head = -1;
            else m_pos = m_pos + 1;
          end
        end else if (h[rcv] && m_pos == rend) begin
          m_head = -m_head; e_ok = 1'b1; m_e[0] = 0; m_e[1] = 0;
          m_spd = (m_spd - SSTEP < SMIN) ? SMIN : m_spd - SSTEP;
          if (m_sq != 0 && m_s0 < (1 << SW) - 1) m_s0++;
        end else begin
          if (h[rcv]) begin
            e_early[rcv] = 1'b1;
            m_e[rcv]++;
            if (m_e[rcv] == ELIM) lose = 1;
          end
          if (!lose && step) begin
            if (m_pos == rend) begin e_miss[rcv] = 1'b1; lose = 1; end
            else m_pos = m_pos + m_head;
          end
          if (lose) begin
            m_ph = M_POINT;
            if (m_sq != 0)     m_s0 = 0;
            else if (rcv != 0) m_s0 = (m_s0 + 1) % (1 << SW);
            else               m_s1 = (m_s1 + 1) % (1 << SW);
          end
        end
      end
      M_POINT: begin
        m_spd = SINIT; m_e[0] = 0; m_e[1] = 0; m_ph = M_SERVE;
        if (m_sq != 0) m_srv = 0;
        else begin
          m_srv = 1 - m_srv;
          if (m_s0 == WINS || m_s1 == WINS) begin
            m_ph = M_OVER; m_win = (m_s1 == WINS) ? 1 : 0;
          end
        end
      end
      default: if (st || h != 2'b00) begin
        m_ph = M_SERVE; m_s0 = 0; m_s1 = 0; m_sq = int'(sq);
        m_srv = sq ? 0 : 1 - m_win;
      end
    endcase
    m_tick = (m_ph != ph0 || step) ? 0 : m_tick + 1;
  endtask

  task automatic check_all();
    chk("leds", 32'(leds), 32'(e_leds));
    chk("score0", 32'(score0), 32'(m_s0));
    chk("score1", 32'(score1), 32'(m_s1));
    chk("ball_speed", 32'(ball_speed), 32'(m_spd));
    chk("server", 32'(server), 32'(m_srv));
    chk("winner", 32'(winner), 32'(m_win));
    chk("hit_ok", 32'(hit_ok), 32'(e_ok));
    chk("early", 32'(early), 32'(e_early));
    chk("miss", 32'(miss), 32'(e_miss));
  endtask

  // called at a negedge; returns at the next negedge with outputs checked
  task automatic cycle(input logic [1:0] h, input logic st);
    hit = h; start = st; squash = sq_lvl;
    @(posedge clock);
    model_edge(h, st, sq_lvl);
    @(negedge clock);
    check_all();
    hit = 2'b00; start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (m_ph != ph && n < 400) begin cycle(2'b00, 1'b0); n++; end
    n_assert++;
    assert (n < 400) else begin n_fail++; $error("FAIL wait_phase timeout: waited %0d want < 400", n); end
  endtask

  task automatic wait_dwell(input bit noise);
    int n = 0;
    while (!at_dwell() && n < 400) begin
      cycle({noise && ($urandom_range(0, 3) == 0), 1'b0}, 1'b0);
      n++;
    end
    n_assert++;
    assert (n < 400) else begin n_fail++; $error("FAIL wait_dwell timeout: waited %0d want < 400", n); end
  endtask

  task automatic serve();
    logic [1:0] h;
    wait_phase(M_SERVE);
    h = 2'b00; h[m_srv] = 1'b1;
    cycle(h, 1'b0);
  endtask

  // one tennis point in which only `loser` fails to return
  task automatic play_point(input int loser);
    logic [1:0] h;
    int n = 0;
    serve();
    while (m_ph == M_RALLY && n < 600) begin
      h = 2'b00;
      if (at_dwell() && rcv_of() != loser) h[rcv_of()] = 1'b1;
      cycle(h, 1'b0);
      n++;
    end
    n_assert++;
    assert (n < 600) else begin n_fail++; $error("FAIL play_point timeout: waited %0d want < 600", n); end
    cycle(2'b00, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    chk("reset_leds", 32'(leds), 32'h01);
    chk("reset_speed", 32'(ball_speed), SINIT);

    // serve, walk, return by player 1, miss by player 0
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b0);
    serve();
    wait_dwell(1'b0);
    cycle(2'b10, 1'b0);
    chk("return_speed", 32'(ball_speed), 3);
    chk("return_hit_ok", 32'(hit_ok), 1);
    wait_dwell(1'b0);
    wait_phase(M_POINT);
    chk("miss0_pulse", 32'(miss), 32'b01);
    cycle(2'b00, 1'b0);
    chk("miss0_score1", 32'(score1), 1);
    chk("miss0_server", 32'(server), 1);
    chk("miss0_speed", 32'(ball_speed), SINIT);

    // player 1 serves and then misses the return
    play_point(1);
    chk("miss1_score0", 32'(score0), 1);

    // early-swing limit by player 1
    serve();
    repeat (3) cycle(2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(2'b10, 1'b0);
      chk("early1_pulse", 32'(early), 32'b10);
      cycle(2'b00, 1'b0);
    end
    chk("early_score0", 32'(score0), 2);

    // game over and restart by a hit
    play_point(1);
    chk("over_winner", 32'(winner), 0);
    cycle(2'b00, 1'b0);
    chk("over_leds", 32'(leds), 32'h00);
    cycle(2'b01, 1'b0);
    chk("restart_score0", 32'(score0), 0);
    chk("restart_server", 32'(server), 1);
    cycle(2'b00, 1'b0);
    chk("restart_leds", 32'(leds), 32'h80);

    // squash: four returns with player-1 noise, then a miss
    @(negedge clock);
    do_reset();
    sq_lvl = 1'b1;
    cycle(2'b00, 1'b1);
    serve();
    for (int r = 0; r < 4; r++) begin
      wait_dwell(1'b1);
      cycle(2'b11, 1'b0);
    end
    chk("squash_score0", 32'(score0), 4);
    wait_dwell(1'b1);
    wait_phase(M_POINT);
    chk("squash_miss_score0", 32'(score0), 0);
    cycle(2'b00, 1'b0);

    // speed floor, then reset mid-rally
    do_reset();
    sq_lvl = 1'b0;
    cycle(2'b00, 1'b1);
    serve();
    for (int r = 0; r < 6; r++) begin
      logic [1:0] h;
      wait_dwell(1'b0);
      h = 2'b00; h[rcv_of()] = 1'b1;
      cycle(h, 1'b0);
      chk("speed_floor", 32'(ball_speed), (3 - r > SMIN) ? 3 - r : SMIN);
    end
    repeat (3) cycle(2'b00, 1'b0);
    do_reset();
    chk("midreset_leds", 32'(leds), 32'h01);
    chk("midreset_speed", 32'(ball_speed), SINIT);

    // random play
    for (int i = 0; i < 2500; i++) begin
      if (i == 1500) do_reset();
      rh = 2'b00; rs = 1'b0;
      if ($urandom_range(0, 99) < 2) sq_lvl = ~sq_lvl;
      if (m_ph == M_SERVE && $urandom_range(0, 2) == 0) rh[m_srv] = 1'b1;
      if (at_dwell() && $urandom_range(0, 2) == 0) rh[rcv_of()] = 1'b1;
      if ($urandom_range(0, 29) == 0) rh[0] = 1'b1;
      if ($urandom_range(0, 29) == 0) rh[1] = 1'b1;
      if ($urandom_range(0, 24) == 0) rs = 1'b1;
      cycle(rh, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
